// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the state encoding, parameter defaults and the register-zero constant.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ERROR    = 2'd3
    } hz_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_CNT_W          = 32;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a five-stage pipeline: data-memory waits,
// taken-branch squashing and load-use interlock, plus a stall-cycle counter.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_RUN      | normal issue; evaluates memory wait, branch and load-use hazards
// ST_MEM_WAIT | data memory busy; whole pipeline frozen until dmem_ready
// ST_FLUSH    | second bubble after a taken branch (ID/EX cleared once more)
// ST_ERROR    | memory access timed out; pipeline frozen and flushed until rst
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EXmemRead,
    input  logic [4:0]       ID_EXregisterRt,
    input  logic [4:0]       IF_IDregisterRs,
    input  logic [4:0]       IF_IDregisterRt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             enable_pc,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              timeout_q;

    stage_en_t en;
    logic      fl_if_id, fl_id_ex;
    logic      wait_load, wait_inc, timeout_set;
    logic      hazard;

    assign hazard = load_use_hit(ID_EXmemRead, ID_EXregisterRt, IF_IDregisterRs, IF_IDregisterRt);

    always_comb begin
        state_d     = state_q;
        en          = '1;
        fl_if_id    = 1'b0;
        fl_id_ex    = 1'b0;
        wait_load   = 1'b0;
        wait_inc    = 1'b0;
        timeout_set = 1'b0;

        if (rst) begin
            en       = '0;
            fl_if_id = 1'b1;
            fl_id_ex = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        en        = '0;
                        wait_load = 1'b1;
                        state_d   = ST_MEM_WAIT;
                    end else if (branch_taken) begin
                        fl_if_id = 1'b1;
                        fl_id_ex = 1'b1;
                        state_d  = ST_FLUSH;
                    end else if (hazard) begin
                        en.pc    = 1'b0;
                        en.if_id = 1'b0;
                        fl_id_ex = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // Completion cycle releases the pipeline; hazards are re-evaluated next cycle.
                    if (dmem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        en = '0;
                        if (wait_cnt_q == WAIT_LIMIT) begin
                            timeout_set = 1'b1;
                            state_d     = ST_ERROR;
                        end else begin
                            wait_inc = 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    fl_id_ex = 1'b1;
                    state_d  = ST_RUN;
                end
                ST_ERROR: begin
                    en       = '0;
                    fl_if_id = 1'b1;
                    fl_id_ex = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_q | timeout_set;
            if (wait_load) begin
                wait_cnt_q <= WAIT_W'(1);
            end else if (wait_inc && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end else if (state_d == ST_RUN) begin
                wait_cnt_q <= '0;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (~&en),
        .count(stall_cycles)
    );

    assign enable_pc     = en.pc;
    assign enable_IF_ID  = en.if_id;
    assign enable_ID_EX  = en.id_ex;
    assign enable_EX_MEM = en.ex_mem;
    assign enable_MEM_WB = en.mem_wb;
    assign flush_IF_ID   = fl_if_id;
    assign flush_ID_EX   = fl_id_ex;
    assign mem_timeout   = timeout_q & ~rst;
    assign state_o       = state_q;

endmodule
